// File: rtl/sketch_ingress_ctrl.sv
// sketch_ingress_ctrl
// Front end for the count-min sketch. It round-robin arbitrates NUM_CH address
// request streams onto the single sketch input port and computes the NUM_HASH
// row indices for each address. An issue is held back for one cycle when its
// row index matches the previous issue in any lane, because the sketch
// commits a write one cycle after it reads. Addresses whose minimum count
// equals cfg_threshold are reported as hot.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   cfg_enable               allow grants and hot reports
//   cfg_threshold            hot threshold (0 disables reporting)
//   req_valid/req_addr       per-channel requests (channel c at [c*ADDR_SIZE +: ADDR_SIZE])
//   req_ready                combinational per-channel accept
//   sk_input_*               registered request toward the sketch
//   sk_output_*              sketch result (address plus per-lane counts)
//   hot_valid/addr/cnt       one-cycle hot report; addr/cnt hold between reports
//   stat_issued, stat_stall  wrapping accept and hazard-stall counters
module sketch_ingress_ctrl #(
  parameter int NUM_CH    = 2,
  parameter int W         = 4096,
  parameter int NUM_HASH  = 4,
  parameter int HASH_SIZE = $clog2(W),
  parameter int ADDR_SIZE = 22,
  parameter int CNT_SIZE  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_enable,
  input  logic [CNT_SIZE-1:0]         cfg_threshold,
  input  logic [NUM_CH-1:0]           req_valid,
  input  logic [NUM_CH*ADDR_SIZE-1:0] req_addr,
  output logic [NUM_CH-1:0]           req_ready,
  output logic                        sk_input_valid,
  output logic [ADDR_SIZE-1:0]        sk_input_addr,
  output logic [HASH_SIZE-1:0]        sk_input_hash_array [0:NUM_HASH-1],
  input  logic                        sk_output_valid,
  input  logic [ADDR_SIZE-1:0]        sk_output_addr,
  input  logic [CNT_SIZE-1:0]         sk_output_cnt_array [0:NUM_HASH-1],
  output logic                        hot_valid,
  output logic [ADDR_SIZE-1:0]        hot_addr,
  output logic [CNT_SIZE-1:0]         hot_cnt,
  output logic [31:0]                 stat_issued,
  output logic [31:0]                 stat_stall
);

  localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int NCHUNK = (ADDR_SIZE + HASH_SIZE - 1) / HASH_SIZE;

  // Lane hash: rotate left by 7*lane, then XOR-fold HASH_SIZE-bit chunks
  // (top chunk zero-padded).
  function automatic logic [HASH_SIZE-1:0] hash_lane(input logic [ADDR_SIZE-1:0] a,
                                                     input int unsigned lane);
    logic [2*ADDR_SIZE-1:0]      dbl;
    logic [NCHUNK*HASH_SIZE-1:0] pad;
    logic [HASH_SIZE-1:0]        h;
    int unsigned                 sh;
    sh  = (7 * lane) % ADDR_SIZE;
    dbl = {a, a} << sh;
    pad = '0;
    pad[ADDR_SIZE-1:0] = dbl[2*ADDR_SIZE-1:ADDR_SIZE];
    h = '0;
    for (int unsigned k = 0; k < NCHUNK; k++) h ^= pad[k*HASH_SIZE +: HASH_SIZE];
    return h;
  endfunction

  logic [PTR_W-1:0]     ptr, cand, ptr_next;
  logic                 any_valid, hazard, grant, hot_hit;
  logic [ADDR_SIZE-1:0] cand_addr;
  logic [HASH_SIZE-1:0] cand_hash [0:NUM_HASH-1];
  logic [CNT_SIZE-1:0]  min_cnt;

  always_comb begin
    any_valid = 1'b0;
    cand      = '0;
    for (int unsigned off = 0; off < NUM_CH; off++) begin
      if (!any_valid && req_valid[(32'(ptr) + off) % NUM_CH]) begin
        any_valid = 1'b1;
        cand      = PTR_W'((32'(ptr) + off) % NUM_CH);
      end
    end
    cand_addr = req_addr[cand*ADDR_SIZE +: ADDR_SIZE];
    hazard = 1'b0;
    for (int unsigned i = 0; i < NUM_HASH; i++) begin
      cand_hash[i] = hash_lane(cand_addr, i);
      if (sk_input_valid && (cand_hash[i] == sk_input_hash_array[i])) hazard = 1'b1;
    end
    grant     = any_valid && cfg_enable && !hazard;
    req_ready = '0;
    if (grant) req_ready[cand] = 1'b1;
    ptr_next  = (cand == PTR_W'(NUM_CH - 1)) ? '0 : cand + 1'b1;
  end

  always_comb begin
    min_cnt = sk_output_cnt_array[0];
    for (int unsigned i = 1; i < NUM_HASH; i++)
      if (sk_output_cnt_array[i] < min_cnt) min_cnt = sk_output_cnt_array[i];
    // Equality, not >=, so each address is reported once per crossing.
    hot_hit = sk_output_valid && cfg_enable && (cfg_threshold != '0) &&
              (min_cnt == cfg_threshold);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr            <= '0;
      sk_input_valid <= 1'b0;
      sk_input_addr  <= '0;
      for (int unsigned i = 0; i < NUM_HASH; i++) sk_input_hash_array[i] <= '0;
      hot_valid      <= 1'b0;
      hot_addr       <= '0;
      hot_cnt        <= '0;
      stat_issued    <= '0;
      stat_stall     <= '0;
    end else begin
      if (grant) begin
        ptr         <= ptr_next;
        stat_issued <= stat_issued + 32'd1;
      end
      if (any_valid && cfg_enable && hazard) stat_stall <= stat_stall + 32'd1;
      sk_input_valid <= grant;
      sk_input_addr  <= grant ? cand_addr : '0;
      for (int unsigned i = 0; i < NUM_HASH; i++)
        sk_input_hash_array[i] <= grant ? cand_hash[i] : '0;
      hot_valid <= hot_hit;
      if (hot_hit) begin
        hot_addr <= sk_output_addr;
        hot_cnt  <= min_cnt;
      end
    end
  end

endmodule

// File: tb/tb_sketch_ingress_ctrl.sv
// Self-checking bench for sketch_ingress_ctrl: an ideal count-min sketch
// emulator on the sketch port, a cycle-level reference model, a directed
// vector table, hand-written corner sequences and a randomized phase.
module tb_sketch_ingress_ctrl;

  localparam int NCH = 2;
  localparam int AW  = 22;
  localparam int HW  = 12;
  localparam int NH  = 4;
  localparam int WD  = 4096;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_enable = 1'b0;
  logic [31:0]     cfg_threshold = '0;
  logic [NCH-1:0]  req_valid = '0;
  logic [NCH*AW-1:0] req_addr = '0;
  logic [NCH-1:0]  req_ready;
  logic            sk_input_valid;
  logic [AW-1:0]   sk_input_addr;
  logic [HW-1:0]   sk_input_hash_array [0:NH-1];
  logic            sk_output_valid = 1'b0;
  logic [AW-1:0]   sk_output_addr = '0;
  logic [31:0]     sk_output_cnt_array [0:NH-1];
  logic            hot_valid;
  logic [AW-1:0]   hot_addr;
  logic [31:0]     hot_cnt;
  logic [31:0]     stat_issued, stat_stall;

  always #5 clk = ~clk;

  sketch_ingress_ctrl #(.NUM_CH(NCH), .W(WD), .NUM_HASH(NH), .HASH_SIZE(HW),
                        .ADDR_SIZE(AW), .CNT_SIZE(32)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_threshold(cfg_threshold),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .sk_input_valid(sk_input_valid), .sk_input_addr(sk_input_addr),
    .sk_input_hash_array(sk_input_hash_array),
    .sk_output_valid(sk_output_valid), .sk_output_addr(sk_output_addr),
    .sk_output_cnt_array(sk_output_cnt_array),
    .hot_valid(hot_valid), .hot_addr(hot_addr), .hot_cnt(hot_cnt),
    .stat_issued(stat_issued), .stat_stall(stat_stall));

  // Ideal sketch: two-cycle latency, increments never lost.
  int unsigned e_cnt [NH][WD];
  logic          s1_v = 1'b0;
  logic [AW-1:0] s1_addr = '0;
  logic [31:0]   s1_cnt [NH];

  initial for (int i = 0; i < NH; i++) begin
    s1_cnt[i] = '0;
    sk_output_cnt_array[i] = '0;
  end

  always @(posedge clk) begin
    s1_v    <= sk_input_valid;
    s1_addr <= sk_input_addr;
    for (int i = 0; i < NH; i++) begin
      s1_cnt[i] <= e_cnt[i][sk_input_hash_array[i]] + (sk_input_valid ? 32'd1 : 32'd0);
      if (sk_input_valid)
        e_cnt[i][sk_input_hash_array[i]] <= e_cnt[i][sk_input_hash_array[i]] + 1;
      sk_output_cnt_array[i] <= s1_cnt[i];
    end
    sk_output_valid <= s1_v;
    sk_output_addr  <= s1_addr;
  end

  // Reference model state.
  typedef struct packed {
    logic [31:0]      due;
    logic [AW-1:0]    addr;
    logic [NH-1:0][31:0] cnt;
  } pend_t;

  pend_t       pend[$];
  int unsigned m_cnt [NH][WD];
  int          m_ptr = 0;
  logic        m_known = 1'b0;
  logic        m_iv = 1'b0, m_hv = 1'b0;
  logic [AW-1:0] m_iaddr = '0, m_haddr = '0;
  logic [HW-1:0] m_ihash [NH];
  logic [31:0] m_hcnt = '0, m_issued = '0, m_stall = '0;

  int n_vec = 0, n_bad = 0, cyc = 0;
  int hot_seen = 0, hot_cyc = -1;
  logic [31:0] last5 [NH];

  initial for (int i = 0; i < NH; i++) begin
    m_ihash[i] = '0;
    last5[i] = '0;
  end

  // Rotation sends bit k to (k+sh) mod AW; folding sends that to bit mod HW.
  function automatic logic [HW-1:0] ref_hash(input logic [AW-1:0] a, input int lane);
    logic [HW-1:0] h;
    int sh;
    h  = '0;
    sh = (7 * lane) % AW;
    for (int k = 0; k < AW; k++) h[((k + sh) % AW) % HW] ^= a[k];
    return h;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic rn, input logic en, input logic [31:0] thr,
                      input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    int          cidx;
    logic        found, haz, gnt, sko_exp, hv_n;
    logic [1:0]  exp_rdy;
    logic [HW-1:0] ch [NH];
    logic [AW-1:0] caddr;
    pend_t       p, np;
    logic [31:0] mn;
    @(negedge clk);
    rst_n = rn; cfg_enable = en; cfg_threshold = thr; req_valid = v; req_addr = {a1, a0};
    #1;
    found = 1'b0; cidx = 0;
    for (int k = 0; k < NCH; k++)
      if (!found && v[(m_ptr + k) % NCH]) begin found = 1'b1; cidx = (m_ptr + k) % NCH; end
    caddr = (cidx == 0) ? a0 : a1;
    haz = 1'b0;
    for (int i = 0; i < NH; i++) begin
      ch[i] = ref_hash(caddr, i);
      if (m_iv && ch[i] == m_ihash[i]) haz = 1'b1;
    end
    gnt = found && en && !haz;
    exp_rdy = '0;
    if (gnt) exp_rdy[cidx] = 1'b1;
    sko_exp = (pend.size() > 0) && (pend[0].due == 32'(cyc));

    if (hot_valid === 1'b1) begin hot_seen++; hot_cyc = cyc; end
    if (sk_output_valid && sk_output_addr == 22'h5)
      for (int i = 0; i < NH; i++) last5[i] = sk_output_cnt_array[i];

    if (m_known) begin
      if (rn) check("req_ready", 64'(req_ready), 64'(exp_rdy));
      check("sk_input_valid", 64'(sk_input_valid), 64'(m_iv));
      check("sk_input_addr", 64'(sk_input_addr), 64'(m_iaddr));
      for (int i = 0; i < NH; i++) check("sk_input_hash", 64'(sk_input_hash_array[i]), 64'(m_ihash[i]));
      check("hot_valid", 64'(hot_valid), 64'(m_hv));
      check("hot_addr", 64'(hot_addr), 64'(m_haddr));
      check("hot_cnt", 64'(hot_cnt), 64'(m_hcnt));
      check("stat_issued", 64'(stat_issued), 64'(m_issued));
      check("stat_stall", 64'(stat_stall), 64'(m_stall));
      check("sk_output_valid", 64'(sk_output_valid), 64'(sko_exp));
      if (sko_exp) begin
        check("sk_output_addr", 64'(sk_output_addr), 64'(pend[0].addr));
        for (int i = 0; i < NH; i++) check("sk_output_cnt", 64'(sk_output_cnt_array[i]), 64'(pend[0].cnt[i]));
      end
    end

    hv_n = 1'b0; mn = '0; p = '0;
    if (sko_exp) begin
      p  = pend.pop_front();
      mn = p.cnt[0];
      for (int i = 1; i < NH; i++) if (p.cnt[i] < mn) mn = p.cnt[i];
      hv_n = en && (thr != 0) && (mn == thr);
    end
    if (!rn) begin
      m_known = 1'b1; m_ptr = 0; m_iv = 1'b0; m_iaddr = '0; m_hv = 1'b0;
      m_haddr = '0; m_hcnt = '0; m_issued = '0; m_stall = '0;
      for (int i = 0; i < NH; i++) m_ihash[i] = '0;
    end else begin
      m_hv = hv_n;
      if (hv_n) begin m_haddr = p.addr; m_hcnt = mn; end
      if (found && en && haz) m_stall++;
      m_iv = gnt;
      m_iaddr = gnt ? caddr : '0;
      for (int i = 0; i < NH; i++) m_ihash[i] = gnt ? ch[i] : '0;
      if (gnt) begin
        m_issued++;
        m_ptr = (cidx + 1) % NCH;
        np.due = 32'(cyc + 3);
        np.addr = caddr;
        for (int i = 0; i < NH; i++) begin
          m_cnt[i][ch[i]]++;
          np.cnt[i] = m_cnt[i][ch[i]];
        end
        pend.push_back(np);
      end
    end
    cyc++;
  endtask

  typedef struct {
    logic          en;
    logic [1:0]    valid;
    logic [AW-1:0] a0, a1;
    logic [1:0]    exp_ready;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int t1;
    logic [1:0] rv;
    logic [AW-1:0] ra0, ra1;
    logic [31:0] rthr;
    logic ren, rrn;

    // Vector table: same-address hazard toggle, two-channel alternation,
    // enable drop and resume at the stored pointer.
    for (int k = 0; k < 16; k++) tbl.push_back('{1'b1, 2'b01, 22'h5, 22'h0, (k % 2 == 0) ? 2'b01 : 2'b00});
    for (int k = 0; k < 8; k++)  tbl.push_back('{1'b1, 2'b11, 22'h1, 22'h2, (k % 2 == 0) ? 2'b10 : 2'b01});
    for (int k = 0; k < 3; k++)  tbl.push_back('{1'b0, 2'b11, 22'h1, 22'h2, 2'b00});
    tbl.push_back('{1'b1, 2'b11, 22'h1, 22'h2, 2'b10});
    tbl.push_back('{1'b1, 2'b11, 22'h1, 22'h2, 2'b01});

    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'd0, 2'b00, '0, '0);

    // Threshold 3, one address four times: single report after the third accept.
    hot_seen = 0;
    t1 = cyc;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 32'd3, 2'b01, 22'h3, '0);
      step(1'b1, 1'b1, 32'd3, 2'b00, '0, '0);
    end
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 32'd3, 2'b00, '0, '0);
    check("t1_hot_pulses", 64'(hot_seen), 64'd1);
    check("t1_hot_cycle", 64'(hot_cyc - t1), 64'd8);
    check("t1_hot_addr", 64'(hot_addr), 64'h3);
    check("t1_hot_cnt", 64'(hot_cnt), 64'd3);
    check("t1_issued", 64'(stat_issued), 64'd4);
    check("t1_stall", 64'(stat_stall), 64'd0);

    for (int k = 0; k < tbl.size(); k++) begin
      step(1'b1, tbl[k].en, 32'd3, tbl[k].valid, tbl[k].a0, tbl[k].a1);
      check("tbl_ready", 64'(req_ready), 64'(tbl[k].exp_ready));
      if (k == 16) begin
        check("t2_issued", 64'(stat_issued), 64'd12);
        check("t2_stall", 64'(stat_stall), 64'd8);
      end
      if (k == 24) begin
        check("t3_issued", 64'(stat_issued), 64'd20);
        check("t3_stall", 64'(stat_stall), 64'd8);
      end
    end
    for (int i = 0; i < NH; i++) check("t2_final_cnt", 64'(last5[i]), 64'd8);

    // Reset mid-stream, then the first grant goes to channel 0.
    step(1'b0, 1'b1, 32'd0, 2'b11, 22'h1, 22'h2);
    step(1'b1, 1'b1, 32'd0, 2'b11, 22'h1, 22'h2);
    check("t5_first_grant", 64'(req_ready), 64'h1);
    check("t5_issued", 64'(stat_issued), 64'd0);
    check("t5_stall", 64'(stat_stall), 64'd0);
    check("t5_sk_valid", 64'(sk_input_valid), 64'd0);
    check("t5_hot_addr", 64'(hot_addr), 64'd0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 32'd0, 2'b11, 22'h1, 22'h2);

    // Threshold 0 never reports.
    hot_seen = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 32'd0, 2'b01, 22'h7, '0);
      step(1'b1, 1'b1, 32'd0, 2'b00, '0, '0);
    end
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 32'd0, 2'b00, '0, '0);
    check("t6_hot_pulses", 64'(hot_seen), 64'd0);
    check("t6_hot_addr", 64'(hot_addr), 64'd0);
    check("t6_hot_cnt", 64'(hot_cnt), 64'd0);

    // Randomized traffic against the reference model.
    rthr = 32'd2;
    for (int k = 0; k < 600; k++) begin
      if (k % 64 == 0) rthr = $urandom_range(0, 6);
      rrn = ($urandom_range(0, 99) != 0);
      ren = ($urandom_range(0, 9) != 0);
      rv  = 2'($urandom_range(0, 3));
      ra0 = ($urandom_range(0, 1) != 0) ? AW'(32'h100 + $urandom_range(0, 5)) : AW'($urandom);
      ra1 = ($urandom_range(0, 1) != 0) ? AW'(32'h100 + $urandom_range(0, 5)) : AW'($urandom);
      step(rrn, ren, rthr, rv, ra0, ra1);
    end
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 32'd0, 2'b00, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
